// File: rtl/axi2mem_rd_sequencer.sv
// Turns one AXI INCR read burst into paired 32-bit TCDM reads (lane 0 = low word, lane 1 = high word)
// and forwards the responses to the two-lane read buffer, throttled by per-lane buffer credits.
module axi2mem_rd_sequencer #(
    parameter int AW             = 32,
    parameter int LD_BUFFER_SIZE = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [AW-1:0]       cmd_addr_i,
    input  logic [7:0]          cmd_len_i,
    input  logic [5:0]          cmd_id_i,

    output logic [1:0]          tcdm_req_o,
    output logic [1:0][AW-1:0]  tcdm_add_o,
    output logic [1:0]          tcdm_wen_o,
    output logic [1:0][3:0]     tcdm_be_o,
    input  logic [1:0]          tcdm_gnt_i,
    input  logic [1:0]          tcdm_r_valid_i,
    input  logic [1:0][31:0]    tcdm_r_rdata_i,

    output logic [1:0]          rd_data_push_req_o,
    output logic [1:0][31:0]    rd_data_push_dat_o,
    output logic [5:0]          rd_data_push_id_o,
    output logic                rd_data_push_last_o,
    input  logic                rd_data_pop_i,

    output logic                busy_o
);

    localparam int CW = $clog2(LD_BUFFER_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      base_q;
    logic [7:0]         len_q;
    logic [5:0]         id_q;
    logic [1:0][8:0]    iss_cnt_q, iss_cnt_d;
    logic [1:0][8:0]    rsp_cnt_q, rsp_cnt_d;
    logic [1:0][CW-1:0] credit_q;
    logic [1:0]         fire;
    logic [1:0]         push;
    logic [8:0]         beats;
    logic               cmd_fire;

    assign beats       = {1'b0, len_q} + 9'd1;
    assign cmd_fire    = cmd_valid_i & (state_q == IDLE);
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

    assign tcdm_wen_o          = 2'b11;
    assign tcdm_be_o           = '1;
    assign rd_data_push_req_o  = push;
    assign rd_data_push_dat_o  = tcdm_r_rdata_i;
    assign rd_data_push_id_o   = id_q;
    assign rd_data_push_last_o = push[0] & (rsp_cnt_q[0] == {1'b0, len_q});

    for (genvar i = 0; i < 2; i++) begin : g_lane
        assign tcdm_req_o[i] = (state_q == BURST) && (iss_cnt_q[i] <= {1'b0, len_q})
                               && (credit_q[i] != '0);
        assign tcdm_add_o[i] = base_q + (AW'(iss_cnt_q[i]) << 3) + AW'(4 * i);
        assign fire[i]       = tcdm_req_o[i] & tcdm_gnt_i[i];
        // Responses seen in IDLE belong to a burst that a reset already abandoned.
        assign push[i]       = tcdm_r_valid_i[i] & (state_q != IDLE);
        assign iss_cnt_d[i]  = iss_cnt_q[i] + {8'd0, fire[i]};
        assign rsp_cnt_d[i]  = rsp_cnt_q[i] + {8'd0, push[i]};

        // Credits mirror free buffer slots and deliberately survive from one burst to the next.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                credit_q[i] <= CW'(LD_BUFFER_SIZE);
            end else if (fire[i] && !rd_data_pop_i) begin
                credit_q[i] <= credit_q[i] - CW'(1);
            end else if (!fire[i] && rd_data_pop_i) begin
                credit_q[i] <= credit_q[i] + CW'(1);
            end
        end

        a_no_pop_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
            !(rd_data_pop_i && (credit_q[i] == CW'(LD_BUFFER_SIZE)) && !fire[i]));

        a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
            tcdm_r_valid_i[i] |-> ((state_q != IDLE) && (rsp_cnt_q[i] < iss_cnt_q[i])));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions look at the post-update counters so the FSM leaves on the completing edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if ((iss_cnt_d[0] == beats) && (iss_cnt_d[1] == beats)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((rsp_cnt_d[0] == beats) && (rsp_cnt_d[1] == beats)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
        end else if (cmd_fire) begin
            base_q <= cmd_addr_i & ~AW'(7);
            len_q  <= cmd_len_i;
            id_q   <= cmd_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else if (cmd_fire) begin
            iss_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            iss_cnt_q <= iss_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi2mem_rd_sequencer.sv
// Bench for axi2mem_rd_sequencer: random grants/pops checked every cycle against a
// burst-level model (address list, credit counts, one-cycle memory latency).
module tb_axi2mem_rd_sequencer;

    localparam int AW   = 32;
    localparam int SIZE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic [7:0]        cmd_len;
    logic [5:0]        cmd_id;
    logic [1:0]        req;
    logic [1:0][31:0]  add;
    logic [1:0]        wen;
    logic [1:0][3:0]   be;
    logic [1:0]        gnt;
    logic [1:0]        r_valid = 2'b00;
    logic [1:0][31:0]  r_rdata;
    logic [1:0]        push_req;
    logic [1:0][31:0]  push_dat;
    logic [5:0]        push_id;
    logic              push_last;
    logic              pop;
    logic              busy;

    int total = 0;
    int bad   = 0;

    int         gnt_pct;
    logic [1:0] gnt_mask;
    int         pop_mode;
    int         pop_pct;

    int          credit[2];
    bit          active;
    int          beats;
    int          issued[2];
    int          responded[2];
    bit          pend[2];
    logic [31:0] pend_addr[2];
    logic [31:0] m_base;
    logic [5:0]  m_id;
    bit          cmd_pending;

    logic        obs_ready;
    logic [1:0]  obs_req;
    logic [31:0] obs_add[2];
    logic [1:0]  obs_push;
    logic        obs_last;
    int          obs_fire[2];
    int          obs_push_cnt[2];
    int          obs_last_cnt;

    always #5 clk = ~clk;

    axi2mem_rd_sequencer #(.AW(AW), .LD_BUFFER_SIZE(SIZE)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_addr_i          (cmd_addr),
        .cmd_len_i           (cmd_len),
        .cmd_id_i            (cmd_id),
        .tcdm_req_o          (req),
        .tcdm_add_o          (add),
        .tcdm_wen_o          (wen),
        .tcdm_be_o           (be),
        .tcdm_gnt_i          (gnt),
        .tcdm_r_valid_i      (r_valid),
        .tcdm_r_rdata_i      (r_rdata),
        .rd_data_push_req_o  (push_req),
        .rd_data_push_dat_o  (push_dat),
        .rd_data_push_id_o   (push_id),
        .rd_data_push_last_o (push_last),
        .rd_data_pop_i       (pop),
        .busy_o              (busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // TCDM memory: answers exactly one cycle after each grant.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            r_valid[i] <= !rst && req[i] && gnt[i];
            r_rdata[i] <= mem_word(add[i]);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            credit[i]    = SIZE;
            issued[i]    = 0;
            responded[i] = 0;
            pend[i]      = 1'b0;
            pend_addr[i] = '0;
        end
        active      = 1'b0;
        beats       = 0;
        m_base      = '0;
        m_id        = '0;
        cmd_pending = 1'b0;
    endtask

    task automatic zero_obs();
        for (int i = 0; i < 2; i++) begin
            obs_fire[i]     = 0;
            obs_push_cnt[i] = 0;
        end
        obs_last_cnt = 0;
    endtask

    // One clock: drive at negedge, compare the whole interface against the model, then advance it.
    task automatic step();
        logic [1:0]  exp_req;
        logic [31:0] exp_add[2];
        logic        exp_last;
        @(negedge clk);
        cmd_valid = cmd_pending;
        for (int i = 0; i < 2; i++)
            gnt[i] = gnt_mask[i] && (int'($urandom_range(99)) < gnt_pct);
        pop = 1'b0;
        if (pop_mode != 0 && credit[0] < SIZE && credit[1] < SIZE) begin
            if (pop_mode == 2) begin
                pop      = 1'b1;
                pop_mode = 0;
            end else begin
                pop = int'($urandom_range(99)) < pop_pct;
            end
        end
        #1;
        total++;
        if (cmd_ready !== !active) begin
            bad++;
            $display("[TB] FAIL cmd_ready: got %b expected %b at %0t", cmd_ready, !active, $time);
        end
        total++;
        if (busy !== active) begin
            bad++;
            $display("[TB] FAIL busy: got %b expected %b at %0t", busy, active, $time);
        end
        for (int i = 0; i < 2; i++) begin
            exp_req[i] = active && issued[i] < beats && credit[i] > 0;
            exp_add[i] = m_base + 32'(issued[i]) * 32'd8 + 32'(4 * i);
            total++;
            if (req[i] !== exp_req[i]) begin
                bad++;
                $display("[TB] FAIL req lane%0d: got %b expected %b at %0t", i, req[i], exp_req[i], $time);
            end
            if (exp_req[i]) begin
                total++;
                if (add[i] !== exp_add[i]) begin
                    bad++;
                    $display("[TB] FAIL addr lane%0d: got %h expected %h at %0t", i, add[i], exp_add[i], $time);
                end
            end
            total++;
            if (push_req[i] !== pend[i]) begin
                bad++;
                $display("[TB] FAIL push_req lane%0d: got %b expected %b at %0t", i, push_req[i], pend[i], $time);
            end
            if (pend[i]) begin
                total++;
                if (push_dat[i] !== mem_word(pend_addr[i])) begin
                    bad++;
                    $display("[TB] FAIL push_dat lane%0d: got %h expected %h at %0t", i, push_dat[i],
                             mem_word(pend_addr[i]), $time);
                end
            end
        end
        exp_last = pend[0] && (responded[0] == beats - 1);
        total++;
        if (push_last !== exp_last) begin
            bad++;
            $display("[TB] FAIL push_last: got %b expected %b at %0t", push_last, exp_last, $time);
        end
        total++;
        if (push_id !== m_id) begin
            bad++;
            $display("[TB] FAIL push_id: got %h expected %h at %0t", push_id, m_id, $time);
        end

        obs_ready = cmd_ready;
        obs_req   = req;
        obs_push  = push_req;
        obs_last  = push_last;
        for (int i = 0; i < 2; i++) begin
            obs_add[i] = add[i];
            if (req[i] && gnt[i]) obs_fire[i]++;
            if (push_req[i]) obs_push_cnt[i]++;
        end
        if (push_last) obs_last_cnt++;

        for (int i = 0; i < 2; i++) begin
            if (pend[i]) responded[i]++;
            pend[i]      = exp_req[i] && gnt[i];
            pend_addr[i] = exp_add[i];
            if (pend[i]) issued[i]++;
            credit[i] = credit[i] + (pop ? 1 : 0) - (pend[i] ? 1 : 0);
        end
        if (active) begin
            if (responded[0] == beats && responded[1] == beats) active = 1'b0;
        end else if (cmd_pending) begin
            m_base       = cmd_addr & ~32'h7;
            beats        = int'(cmd_len) + 1;
            m_id         = cmd_id;
            issued[0]    = 0;
            issued[1]    = 0;
            responded[0] = 0;
            responded[1] = 0;
            active       = 1'b1;
            cmd_pending  = 1'b0;
        end
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
        cmd_addr    = a;
        cmd_len     = l;
        cmd_id      = id;
        cmd_pending = 1'b1;
    endtask

    task automatic finish_burst(input int budget);
        int n = 0;
        while ((cmd_pending || active) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (cmd_pending || active) begin
            bad++;
            $display("[TB] FAIL burst_timeout: still busy after %0d cycles, required done", budget);
        end
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [5:0] id, input int budget);
        start_burst(a, l, id);
        finish_burst(budget);
    endtask

    task automatic refill_credits();
        int n = 0;
        pop_mode = 1;
        pop_pct  = 100;
        while (credit[0] < SIZE && n < 20) begin
            step();
            n++;
        end
        pop_mode = 0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_id    = '0;
        gnt       = 2'b00;
        pop       = 1'b0;
        gnt_mask  = 2'b11;
        gnt_pct   = 100;
        pop_mode  = 0;
        pop_pct   = 0;
        model_reset();
        zero_obs();
        #12;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
        total++; if (req !== 2'b00) begin bad++; $display("[TB] FAIL reset_req: got %b expected 00", req); end
        total++; if (push_req !== 2'b00) begin bad++; $display("[TB] FAIL reset_push: got %b expected 00", push_req); end
        total++; if (push_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b expected 0", push_last); end
        total++; if (push_id !== 6'd0) begin bad++; $display("[TB] FAIL reset_id: got %h expected 00", push_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (wen !== 2'b11) begin bad++; $display("[TB] FAIL wen: got %b expected 11", wen); end
        total++; if (be !== 8'hFF) begin bad++; $display("[TB] FAIL be: got %h expected ff", be); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        refill_credits();
        gnt_mask = 2'b11;
        gnt_pct  = 100;
        start_burst(32'h0000_0100, 8'd0, 6'h15);
        step();
        total++; if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL t1_accept_ready: got %b expected 1", obs_ready); end
        step();
        total++; if (obs_req !== 2'b11) begin bad++; $display("[TB] FAIL t1_req: got %b expected 11", obs_req); end
        total++; if (obs_add[0] !== 32'h100) begin bad++; $display("[TB] FAIL t1_add0: got %h expected 100", obs_add[0]); end
        total++; if (obs_add[1] !== 32'h104) begin bad++; $display("[TB] FAIL t1_add1: got %h expected 104", obs_add[1]); end
        step();
        total++; if (obs_push !== 2'b11) begin bad++; $display("[TB] FAIL t1_push: got %b expected 11", obs_push); end
        total++; if (obs_last !== 1'b1) begin bad++; $display("[TB] FAIL t1_last: got %b expected 1", obs_last); end
        step();
        total++; if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL t1_ready_again: got %b expected 1", obs_ready); end
    endtask

    task automatic test_pop_each_beat();
        refill_credits();
        zero_obs();
        gnt_mask = 2'b11;
        gnt_pct  = 100;
        pop_mode = 1;
        pop_pct  = 100;
        run_burst(32'h0000_0200, 8'd3, 6'h2A, 60);
        pop_mode = 0;
        total++; if (obs_push_cnt[0] !== 4) begin bad++; $display("[TB] FAIL t2_push0: got %0d expected 4", obs_push_cnt[0]); end
        total++; if (obs_push_cnt[1] !== 4) begin bad++; $display("[TB] FAIL t2_push1: got %0d expected 4", obs_push_cnt[1]); end
        total++; if (obs_last_cnt !== 1) begin bad++; $display("[TB] FAIL t2_last_count: got %0d expected 1", obs_last_cnt); end
    endtask

    task automatic test_credit_stall();
        refill_credits();
        zero_obs();
        gnt_mask = 2'b11;
        gnt_pct  = 100;
        start_burst(32'h0000_3000, 8'd7, 6'h07);
        repeat (10) step();
        total++; if (obs_fire[0] !== SIZE) begin bad++; $display("[TB] FAIL t3_grants0: got %0d expected %0d", obs_fire[0], SIZE); end
        total++; if (obs_fire[1] !== SIZE) begin bad++; $display("[TB] FAIL t3_grants1: got %0d expected %0d", obs_fire[1], SIZE); end
        total++; if (obs_req !== 2'b00) begin bad++; $display("[TB] FAIL t3_stalled_req: got %b expected 00", obs_req); end
        pop_mode = 2;
        repeat (6) step();
        total++; if (obs_fire[0] !== SIZE + 1) begin bad++; $display("[TB] FAIL t3_after_pop0: got %0d expected %0d", obs_fire[0], SIZE + 1); end
        total++; if (obs_fire[1] !== SIZE + 1) begin bad++; $display("[TB] FAIL t3_after_pop1: got %0d expected %0d", obs_fire[1], SIZE + 1); end
        pop_mode = 1;
        pop_pct  = 100;
        finish_burst(100);
        pop_mode = 0;
    endtask

    task automatic test_lane_skew();
        refill_credits();
        zero_obs();
        gnt_mask = 2'b01;
        gnt_pct  = 100;
        pop_mode = 1;
        pop_pct  = 100;
        start_burst(32'h0000_0200, 8'd3, 6'h11);
        repeat (6) step();
        total++; if (obs_fire[1] !== 0) begin bad++; $display("[TB] FAIL t4_lane1_held: got %0d expected 0", obs_fire[1]); end
        total++; if (obs_fire[0] !== SIZE) begin bad++; $display("[TB] FAIL t4_lane0_credit: got %0d expected %0d", obs_fire[0], SIZE); end
        gnt_mask = 2'b11;
        finish_burst(100);
        total++; if (obs_fire[1] !== 4) begin bad++; $display("[TB] FAIL t4_lane1_total: got %0d expected 4", obs_fire[1]); end
        pop_mode = 0;
    endtask

    task automatic test_random_bursts();
        logic [31:0] a;
        logic [7:0]  l;
        logic [5:0]  id;
        for (int b = 0; b < 10; b++) begin
            a        = $urandom;
            l        = 8'($urandom_range(15));
            id       = 6'($urandom);
            gnt_mask = 2'b11;
            gnt_pct  = int'($urandom_range(100, 40));
            pop_mode = 1;
            pop_pct  = int'($urandom_range(100, 30));
            run_burst(a, l, id, 500);
        end
        pop_mode = 0;
    endtask

    task automatic test_back_to_back();
        gnt_mask = 2'b11;
        gnt_pct  = 100;
        pop_mode = 1;
        pop_pct  = 100;
        run_burst(32'hFFFF_FFF3, 8'd3, 6'h3F, 100);
        run_burst(32'h0000_0040, 8'd0, 6'h01, 100);
        run_burst(32'h0001_0000, 8'd255, 6'h22, 2000);
        pop_mode = 0;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        refill_credits();
        zero_obs();
        gnt_mask = 2'b11;
        gnt_pct  = 100;
        start_burst(32'h0000_0400, 8'd5, 6'h19);
        while (obs_fire[0] < 2 && n < 20) begin
            step();
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        gnt       = 2'b00;
        pop       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (req !== 2'b00) begin bad++; $display("[TB] FAIL t6_req: got %b expected 00", req); end
        total++; if (push_req !== 2'b00) begin bad++; $display("[TB] FAIL t6_push: got %b expected 00", push_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_busy: got %b expected 0", busy); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        zero_obs();
        pop_mode = 0;
        start_burst(32'h0000_0500, 8'd3, 6'h0C);
        repeat (8) step();
        total++; if (obs_fire[0] !== SIZE) begin bad++; $display("[TB] FAIL t6_credit0: got %0d expected %0d", obs_fire[0], SIZE); end
        total++; if (obs_fire[1] !== SIZE) begin bad++; $display("[TB] FAIL t6_credit1: got %0d expected %0d", obs_fire[1], SIZE); end
        pop_mode = 1;
        pop_pct  = 100;
        finish_burst(100);
        pop_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_pop_each_beat();
        test_credit_stall();
        test_lane_skew();
        test_random_bursts();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
